// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one fixed-latency pipelined FPU between NUM_REQ requesters.
// Optional build macro: FPU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin arbitration.

package fpu_defs;
   localparam int C_CMD = 4;
   localparam logic [C_CMD-1:0] FPU_ADD = 4'd0;
   localparam logic [C_CMD-1:0] FPU_SUB = 4'd1;
   localparam logic [C_CMD-1:0] FPU_MUL = 4'd2;
   localparam logic [C_CMD-1:0] FPU_F2I = 4'd3;
   localparam logic [C_CMD-1:0] FPU_I2F = 4'd4;
endpackage

module fpu_req_arbiter
   import fpu_defs::*;
#(
   parameter int NUM_REQ = 2,
   parameter int LATENCY = 3,
   parameter int C_OP    = 32
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RI,
   input  logic [NUM_REQ-1:0]        Req_SI,
   output logic [NUM_REQ-1:0]        Gnt_SO,
   input  logic [NUM_REQ*C_OP-1:0]   Operand_a_DI,
   input  logic [NUM_REQ*C_OP-1:0]   Operand_b_DI,
   input  logic [NUM_REQ*C_CMD-1:0]  Op_DI,
   output logic                      FPU_Valid_SO,
   output logic [C_OP-1:0]           FPU_Operand_a_DO,
   output logic [C_OP-1:0]           FPU_Operand_b_DO,
   output logic [C_CMD-1:0]          FPU_Op_SO,
   input  logic [C_OP-1:0]           FPU_Result_DI,
   input  logic                      OF_SI,
   input  logic                      UF_SI,
   input  logic                      Zero_SI,
   input  logic                      IX_SI,
   input  logic                      IV_SI,
   input  logic                      Inf_SI,
   output logic [C_OP-1:0]           Result_DO,
   output logic [NUM_REQ-1:0]        Result_Valid_SO,
   output logic [5:0]                ResFlags_DO,
   output logic [NUM_REQ*4-1:0]      Sticky_DO,
   input  logic [NUM_REQ-1:0]        StickyClr_SI,
   input  logic                      Flush_SI,
   output logic                      Flushed_SO
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_e;

   state_e                        state_q, state_d;
   logic [NUM_REQ-1:0]            req_en, gnt;
   logic                          any_gnt;
   logic [IW-1:0]                 win;
   logic                          val_q, val_d;
   logic [C_OP-1:0]               a_q, a_d, b_q, b_d;
   logic [C_CMD-1:0]              op_q, op_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic [LATENCY-1:0]            tv_q, tv_d;
   logic [LATENCY-1:0][IW-1:0]    ti_q, ti_d;
   logic                          ret;
   logic [IW-1:0]                 ret_idx;
   logic [NUM_REQ-1:0][3:0]       st_q, st_d;
`ifndef FPU_ARB_FIXED_PRIO_EN
   logic [IW-1:0]                 ptr_q, ptr_d;
`endif

   assign ret     = tv_q[LATENCY-1];
   assign ret_idx = ti_q[LATENCY-1];

   // pick one winner among enabled requests; grants only while running and not asked to drain
   always_comb begin
      req_en  = (state_q == S_RUN && !Flush_SI && !Rst_RI) ? Req_SI : '0;
      gnt     = '0;
      win     = '0;
      any_gnt = 1'b0;
`ifdef FPU_ARB_FIXED_PRIO_EN
      for (int j = 0; j < NUM_REQ; j++)
         if (!any_gnt && req_en[j]) begin
            any_gnt = 1'b1;
            win     = IW'(j);
            gnt[j]  = 1'b1;
         end
`else
      for (int j = 0; j < NUM_REQ; j++)
         if (!any_gnt && req_en[j] && j >= int'(ptr_q)) begin
            any_gnt = 1'b1;
            win     = IW'(j);
            gnt[j]  = 1'b1;
         end
      for (int j = 0; j < NUM_REQ; j++)
         if (!any_gnt && req_en[j] && j < int'(ptr_q)) begin
            any_gnt = 1'b1;
            win     = IW'(j);
            gnt[j]  = 1'b1;
         end
      ptr_d = !any_gnt ? ptr_q : (win == IW'(NUM_REQ-1)) ? '0 : win + IW'(1);
`endif
   end

   // register the winner's operation and advance the in-flight tag pipeline
   always_comb begin
      val_d   = any_gnt;
      a_d     = any_gnt ? Operand_a_DI[int'(win)*C_OP +: C_OP] : a_q;
      b_d     = any_gnt ? Operand_b_DI[int'(win)*C_OP +: C_OP] : b_q;
      op_d    = any_gnt ? Op_DI[int'(win)*C_CMD +: C_CMD] : op_q;
      idx_d   = any_gnt ? win : idx_q;
      tv_d    = '0;
      ti_d    = '0;
      tv_d[0] = val_q;
      ti_d[0] = idx_q;
      for (int k = 1; k < LATENCY; k++) begin
         tv_d[k] = tv_q[k-1];
         ti_d[k] = ti_q[k-1];
      end
   end

   // route the returning result to its owner and accumulate sticky flags (clear before set)
   always_comb begin
      Result_Valid_SO = '0;
      Result_DO       = ret ? FPU_Result_DI : '0;
      ResFlags_DO     = ret ? {IV_SI, Inf_SI, OF_SI, UF_SI, Zero_SI, IX_SI} : 6'b0;
      st_d            = st_q;
      for (int j = 0; j < NUM_REQ; j++) begin
         Result_Valid_SO[j] = ret && ret_idx == IW'(j);
         st_d[j] = StickyClr_SI[j] ? 4'b0 : st_q[j];
         if (ret && ret_idx == IW'(j))
            st_d[j] = st_d[j] | {IV_SI, OF_SI, UF_SI, IX_SI};
      end
   end

   // run/drain/halt sequencing; halt as soon as the next pipeline state holds no valid tag
   always_comb begin
      state_d = (state_q == S_RUN)   ? (Flush_SI ? S_DRAIN : S_RUN) :
                (state_q == S_DRAIN) ? (!Flush_SI ? S_RUN : (~|tv_d ? S_HALT : S_DRAIN)) :
                                       (Flush_SI ? S_HALT : S_RUN);
   end

   // state registers
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state_q <= S_RUN;
         val_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         idx_q   <= '0;
         tv_q    <= '0;
         ti_q    <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         tv_q    <= tv_d;
         ti_q    <= ti_d;
         st_q    <= st_d;
      end
   end

`ifndef FPU_ARB_FIXED_PRIO_EN
   // round-robin pointer
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`endif

   assign Gnt_SO           = gnt;
   assign FPU_Valid_SO     = val_q;
   assign FPU_Operand_a_DO = a_q;
   assign FPU_Operand_b_DO = b_q;
   assign FPU_Op_SO        = op_q;
   assign Sticky_DO        = st_q;
   assign Flushed_SO       = state_q == S_HALT;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter: directed self-checking bench for fpu_req_arbiter (NUM_REQ=2, LATENCY=3).
module tb_fpu_req_arbiter;
   import fpu_defs::*;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req, gnt, rv, clr;
   logic [63:0]   opa, opb;
   logic [7:0]    op;
   logic          fv;
   logic [31:0]   fa, fb, fres, res;
   logic [3:0]    fop;
   logic          of_i, uf_i, zero_i, ix_i, iv_i, inf_i, flush, flushed;
   logic [5:0]    rflags;
   logic [7:0]    sticky;
   int            tests = 0;
   int            fails = 0;

   fpu_req_arbiter #(.NUM_REQ(2), .LATENCY(3), .C_OP(32)) dut (
      .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req), .Gnt_SO(gnt),
      .Operand_a_DI(opa), .Operand_b_DI(opb), .Op_DI(op),
      .FPU_Valid_SO(fv), .FPU_Operand_a_DO(fa), .FPU_Operand_b_DO(fb), .FPU_Op_SO(fop),
      .FPU_Result_DI(fres), .OF_SI(of_i), .UF_SI(uf_i), .Zero_SI(zero_i), .IX_SI(ix_i),
      .IV_SI(iv_i), .Inf_SI(inf_i), .Result_DO(res), .Result_Valid_SO(rv),
      .ResFlags_DO(rflags), .Sticky_DO(sticky), .StickyClr_SI(clr),
      .Flush_SI(flush), .Flushed_SO(flushed)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req = 2'b01; clr = 2'b00; flush = 1'b0;
      opa = '0; opb = '0; op = '0; fres = '0;
      {of_i, uf_i, zero_i, ix_i, iv_i, inf_i} = '0;
      tick(); tick();
      #1;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_fpu_valid", fv, 1'b0);
      chk("rst_result_valid", rv, 2'b00);
      chk("rst_sticky", sticky, 8'h00);
      chk("rst_flushed", flushed, 1'b0);
      chk("rst_fpu_a", fa, 32'h0);
      rst = 1'b0; req = 2'b00;
      tick();
      req = 2'b01; opa[31:0] = 32'h3f800000; opb[31:0] = 32'h40000000; op[3:0] = FPU_ADD;
      #1;
      chk("single_gnt", gnt, 2'b01);
      tick();
      req = 2'b00;
      #1;
      chk("single_fpu_valid", fv, 1'b1);
      chk("single_fpu_a", fa, 32'h3f800000);
      chk("single_fpu_b", fb, 32'h40000000);
      tick();
      #1;
      chk("single_valid_once", fv, 1'b0);
      chk("single_fpu_a_hold", fa, 32'h3f800000);
      tick();
      #1;
      chk("single_rv_early", rv, 2'b00);
      tick();
      fres = 32'h40400000;
      #1;
      chk("single_rv", rv, 2'b01);
      chk("single_res", res, 32'h40400000);
      chk("single_flags", rflags, 6'b0);
      tick();
      #1;
      chk("single_rv_after", rv, 2'b00);
      chk("single_res_after", res, 32'h0);
      req = 2'b01;
      #1;
      chk("rstmid_gnt", gnt, 2'b01);
      tick();
      req = 2'b00; rst = 1'b1;
      #1;
      chk("rstmid_fpu_valid", fv, 1'b1);
      tick();
      rst = 1'b0; fres = 32'hdeadbeef; iv_i = 1'b1; of_i = 1'b1;
      #1;
      chk("rstmid_fpu_valid_clr", fv, 1'b0);
      tick(); tick();
      #1;
      chk("rstmid_no_rv", rv, 2'b00);
      tick();
      #1;
      chk("rstmid_sticky", sticky, 8'h00);
      chk("rstmid_flushed", flushed, 1'b0);
      iv_i = 1'b0; of_i = 1'b0;
      req = 2'b11; opa = {32'h2, 32'h1}; opb = {32'h20, 32'h10}; op = {FPU_MUL, FPU_ADD};
      #1;
      chk("cont_gnt0_ptr_reset", gnt, 2'b01);
      tick();
      #1;
      chk("cont_gnt1", gnt, 2'b10);
      chk("cont_fpu_a0", fa, 32'h1);
      tick();
      #1;
      chk("cont_gnt2", gnt, 2'b01);
      chk("cont_fpu_a1", fa, 32'h2);
      chk("cont_fpu_b1", fb, 32'h20);
      chk("cont_fpu_op1", fop, FPU_MUL);
      tick();
      #1;
      chk("cont_gnt3", gnt, 2'b10);
      tick();
      req = 2'b00; fres = 32'h11111111;
      #1;
      chk("cont_gnt_idle", gnt, 2'b00);
      chk("cont_rv0", rv, 2'b01);
      chk("cont_res0", res, 32'h11111111);
      tick();
      fres = 32'h22222222; iv_i = 1'b1; ix_i = 1'b1;
      #1;
      chk("cont_rv1", rv, 2'b10);
      chk("cont_res1", res, 32'h22222222);
      chk("flags_resflags", rflags, 6'b100001);
      tick();
      fres = 32'h33333333; iv_i = 1'b0; ix_i = 1'b0;
      #1;
      chk("cont_rv2", rv, 2'b01);
      chk("flags_sticky1", sticky[7:4], 4'b1001);
      chk("flags_sticky0", sticky[3:0], 4'b0000);
      tick();
      fres = 32'h44444444; of_i = 1'b1; clr = 2'b10;
      #1;
      chk("cont_rv3", rv, 2'b10);
      chk("clr_before", sticky[7:4], 4'b1001);
      tick();
      of_i = 1'b0; clr = 2'b00;
      #1;
      chk("clr_collision", sticky, 8'h40);
      chk("cont_rv_done", rv, 2'b00);
      req = 2'b11;
      #1;
      chk("flush_gnt0", gnt, 2'b01);
      tick();
      #1;
      chk("flush_gnt1", gnt, 2'b10);
      tick();
      #1;
      chk("flush_gnt2", gnt, 2'b01);
      tick();
      flush = 1'b1;
      #1;
      chk("flush_gnt_blocked", gnt, 2'b00);
      chk("flush_not_flushed", flushed, 1'b0);
      tick();
      #1;
      chk("drain_gnt", gnt, 2'b00);
      chk("drain_rv0", rv, 2'b01);
      chk("drain_flushed0", flushed, 1'b0);
      tick();
      #1;
      chk("drain_rv1", rv, 2'b10);
      tick();
      #1;
      chk("drain_rv2", rv, 2'b01);
      chk("drain_flushed2", flushed, 1'b0);
      tick();
      flush = 1'b0;
      #1;
      chk("halt_flushed", flushed, 1'b1);
      chk("halt_gnt", gnt, 2'b00);
      chk("halt_rv", rv, 2'b00);
      tick();
      #1;
      chk("resume_gnt", gnt, 2'b10);
      chk("resume_flushed", flushed, 1'b0);
      req = 2'b00;
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fpu_req_arbiter.md
Name: fpu_req_arbiter

Overview:
- Shares one fixed-latency pipelined FPU datapath (add/sub/mul/f2i/i2f plus its exception-flag logic) between NUM_REQ requesters.
- Arbitrates requests and registers the issued operation.
- Tracks in-flight operations with a tag pipeline, routes each result and its flags back to the owning requester, and keeps per-requester sticky exception flags.
- Supports a drain/flush handshake so software can quiesce the FPU before reading flags.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- LATENCY, 3, cycles from FPU_Valid_SO high to result on FPU_Result_DI (1..8).
- C_OP, 32, operand/result width.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous active-high reset.
- Req_SI  in  NUM_REQ  per-requester request; operands held while high.
- Gnt_SO  out  NUM_REQ  one-hot grant, combinational from Req_SI and state.
- Operand_a_DI  in  NUM_REQ*C_OP  operand A per requester.
- Operand_b_DI  in  NUM_REQ*C_OP  operand B per requester.
- Op_DI  in  NUM_REQ*C_CMD  command per requester (C_CMD from fpu_defs).
- FPU_Valid_SO  out  1  issue strobe to FPU.
- FPU_Operand_a_DO  out  C_OP  registered operand A to FPU.
- FPU_Operand_b_DO  out  C_OP  registered operand B to FPU.
- FPU_Op_SO  out  C_CMD  registered command.
- FPU_Result_DI  in  C_OP  FPU result.
- OF_SI, UF_SI, Zero_SI, IX_SI, IV_SI, Inf_SI  in  1 each  FPU exception outputs, aligned with FPU_Result_DI.
- Result_DO  out  C_OP  result, broadcast to all requesters.
- Result_Valid_SO  out  NUM_REQ  one-hot; marks the owner of Result_DO.
- ResFlags_DO  out  6  per-result {IV,Inf,OF,UF,Zero,IX}.
- Sticky_DO  out  NUM_REQ*4  sticky {IV,OF,UF,IX} per requester.
- StickyClr_SI  in  NUM_REQ  clear that requester's sticky flags.
- Flush_SI  in  1  drain request, level.
- Flushed_SO  out  1  high when halted and pipeline empty.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM goes to RUN.
  - Round-robin pointer reset to requester 0.
  - Tag-valid shift register and sticky registers cleared.
- FSM states:
  - RUN: grants allowed. Flush_SI=1 -> DRAIN.
  - DRAIN: no grants. Tag pipeline empty -> HALT.
  - HALT: no grants; Flushed_SO=1. Flush_SI=0 -> RUN.
  - Flush_SI dropped while in DRAIN -> RUN; in-flight results are still delivered.
- Arbitration (RUN only):
  - Round-robin, one grant per cycle.
  - Search starts at pointer.
  - Pointer moves to (granted index + 1) mod NUM_REQ on grant, and is unchanged when nothing is granted.
  - Gnt_SO depends combinationally on Req_SI in the same cycle.
  - The requester drops or changes Req_SI after a grant edge.
- Issue:
  - On the grant edge, operands and command of the winner are registered into the FPU_* outputs and FPU_Valid_SO=1 for exactly one cycle.
  - The winner index is pushed as the tag at stage 0 of a LATENCY-deep {valid, index} shift register.
  - FPU_* outputs hold their last value when not valid.
- Return:
  - When tag stage LATENCY-1 is valid, Result_DO=FPU_Result_DI, ResFlags_DO carries the FPU flags, and Result_Valid_SO[index]=1. All three are combinational from the FPU inputs.
  - Req->Result_Valid latency is LATENCY+1 cycles.
  - Throughput is one op per cycle; there is no backpressure, so requesters accept results unconditionally.
- Sticky flags:
  - On a return edge, Sticky[index] |= {IV,OF,UF,IX}.
  - StickyClr and a set in the same cycle for the same requester: result is the new flags only (clear applied first, then set).
  - Clear has no effect on other requesters.
- Empty detect: pipeline empty = no valid tag bit.
  - HALT is entered the cycle after the last result is delivered.
- Reset mid-operation: tags are cleared, so in-flight results are silently dropped. Stale FPU outputs never assert Result_Valid_SO.

Optional Feature:
- FPU_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins; the pointer is not instantiated.
  - Undefined: round-robin as described above.

Test Plan:
- Single op: Req_SI=01, Op=ADD, LATENCY=3, FPU returns 0x40400000 -> Gnt_SO=01 same cycle; FPU_Valid_SO at T+1; Result_Valid_SO=01 at T+4 with Result_DO=0x40400000.
- Contention: Req_SI=11 held for 4 cycles -> grants 01,10,01,10; results come back in that order, one per cycle, with matching Result_Valid_SO.
- Flags: requester 1 op returns IV_SI=1, IX_SI=1 -> Sticky_DO[7:4]=4'b1001 the cycle after return; Sticky_DO[3:0] stays 0.
- Clear collision: StickyClr_SI=10 in the same cycle as a return for requester 1 with OF_SI=1 -> Sticky_DO[7:4]=4'b0100.
- Flush: 3 ops in flight, Flush_SI=1 with Req_SI=11 -> Gnt_SO=00; all 3 results delivered; Flushed_SO=1 the cycle after the last; Flush_SI=0 -> grants resume next cycle.
- Reset mid-op: Rst_RI pulsed 1 cycle after issue -> no Result_Valid_SO for that op; Sticky_DO=0; FSM in RUN; pointer at 0.
